// File: rtl/shared_ram_arbiter.sv
// Round-robin arbiter sharing one single-port 32-bit SRAM between an APB slave port and a PicoRV32 memory port.
// Define SHARED_RAM_ARB_APB_PRIO_EN to make APB win every tie (fixed priority) instead of round-robin.
module shared_ram_arbiter #(
  parameter int unsigned ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           paddr,
  input  logic                  pwrite,
  input  logic                  psel,
  input  logic                  penable,
  input  logic [31:0]           pwdata,
  output logic [31:0]           prdata,
  output logic                  pready,
  input  logic                  mem_valid,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_wstrb,
  output logic                  mem_ready,
  output logic [31:0]           mem_rdata,
  output logic                  ram_en,
  output logic [3:0]            ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e                state_q;
  logic                  grant_q;
  logic                  wr_q;
  logic                  ram_en_q;
  logic [3:0]            ram_we_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [31:0]           ram_wdata_q;
  logic                  pready_q;
  logic [31:0]           prdata_q;
  logic                  mem_ready_q;
  logic [31:0]           mem_rdata_q;
  logic                  busy_q;

  logic                  apb_req_c;
  logic                  core_req_c;
  logic                  pick_apb_c;
  logic [ADDR_WIDTH-1:0] apb_addr_c;
  logic [ADDR_WIDTH-1:0] core_addr_c;
  logic                  unused_addr_bits;

  assign apb_req_c   = psel & penable;
  assign core_req_c  = mem_valid;
  // Word addresses; upper byte-address bits are dropped so accesses alias within the RAM.
  assign apb_addr_c  = paddr[ADDR_WIDTH+1:2];
  assign core_addr_c = mem_addr[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{paddr, mem_addr};

`ifdef SHARED_RAM_ARB_APB_PRIO_EN
  assign pick_apb_c = apb_req_c;
`else
  logic last_grant_q;

  // APB wins alone, or on a tie when the core was granted last.
  assign pick_apb_c = apb_req_c & (~core_req_c | ~last_grant_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b0;
    end else if (state_q == IDLE && (apb_req_c || core_req_c)) begin
      last_grant_q <= pick_apb_c;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      wr_q        <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 4'h0;
      ram_addr_q  <= '0;
      ram_wdata_q <= 32'h0;
      pready_q    <= 1'b0;
      prdata_q    <= 32'h0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= 32'h0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (apb_req_c || core_req_c) begin
            state_q  <= ACC;
            busy_q   <= 1'b1;
            grant_q  <= pick_apb_c;
            ram_en_q <= 1'b1;
            if (pick_apb_c) begin
              ram_addr_q  <= apb_addr_c;
              ram_wdata_q <= pwdata;
              ram_we_q    <= pwrite ? 4'hF : 4'h0;
              wr_q        <= pwrite;
            end else begin
              ram_addr_q  <= core_addr_c;
              ram_wdata_q <= mem_wdata;
              ram_we_q    <= mem_wstrb;
              wr_q        <= |mem_wstrb;
            end
          end
        end
        ACC: begin
          state_q  <= RSP;
          ram_en_q <= 1'b0;
          ram_we_q <= 4'h0;
        end
        RSP: begin
          // RAM data is valid now; present it with the ready pulse next cycle.
          state_q <= DONE;
          if (grant_q) begin
            pready_q <= 1'b1;
            prdata_q <= wr_q ? 32'h0 : ram_rdata;
          end else begin
            mem_ready_q <= 1'b1;
            mem_rdata_q <= wr_q ? 32'h0 : ram_rdata;
          end
        end
        DONE: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          pready_q    <= 1'b0;
          prdata_q    <= 32'h0;
          mem_ready_q <= 1'b0;
          mem_rdata_q <= 32'h0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign pready    = pready_q;
  assign prdata    = prdata_q;
  assign mem_ready = mem_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// Directed self-checking bench for shared_ram_arbiter with a behavioural single-port RAM.
module tb_shared_ram_arbiter;

  localparam int unsigned AW = 14;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   paddr;
  logic          pwrite, psel, penable;
  logic [31:0]   pwdata, prdata;
  logic          pready;
  logic          mem_valid;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata;
  logic [3:0]    mem_wstrb;
  logic          mem_ready;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  shared_ram_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
    .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
  );

  // Read-first single-port RAM with byte enables, one-cycle read latency.
  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_prdata0"}, prdata, 32'h0);
    chk({tag, "_mrdata0"}, mem_rdata, 32'h0);
    chk({tag, "_pready0"}, 32'(pready), 32'h0);
    chk({tag, "_mready0"}, 32'(mem_ready), 32'h0);
  endtask

  task automatic core_xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                           input logic [31:0] exp_rd, input logic [31:0] exp_word, input string tag);
    mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb;
    tick();
    mem_valid = 1'b0;
    chk({tag, "_acc_en"}, 32'(ram_en), 32'h1);
    chk({tag, "_acc_we"}, 32'(ram_we), 32'(wstrb));
    chk({tag, "_acc_addr"}, 32'(ram_addr), exp_word);
    chk({tag, "_busy"}, 32'(busy), 32'h1);
    if (wstrb != 4'h0) chk({tag, "_acc_wdata"}, ram_wdata, wdata);
    tick();
    chk({tag, "_rsp_en"}, 32'(ram_en), 32'h0);
    chk_idle_outputs({tag, "_rsp"});
    tick();
    chk({tag, "_mready"}, 32'(mem_ready), 32'h1);
    chk({tag, "_mrdata"}, mem_rdata, exp_rd);
    chk({tag, "_done_pready"}, 32'(pready), 32'h0);
    chk({tag, "_done_en"}, 32'(ram_en), 32'h0);
    tick();
    chk_idle_outputs({tag, "_idle"});
    chk({tag, "_idle_busy"}, 32'(busy), 32'h0);
  endtask

  task automatic apb_xfer(input logic [15:0] addr, input logic wr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input logic [31:0] exp_word, input string tag);
    psel = 1'b1; penable = 1'b1; paddr = addr; pwrite = wr; pwdata = wdata;
    tick();
    psel = 1'b0; penable = 1'b0;
    chk({tag, "_acc_en"}, 32'(ram_en), 32'h1);
    chk({tag, "_acc_we"}, 32'(ram_we), wr ? 32'hF : 32'h0);
    chk({tag, "_acc_addr"}, 32'(ram_addr), exp_word);
    tick();
    chk({tag, "_rsp_en"}, 32'(ram_en), 32'h0);
    chk_idle_outputs({tag, "_rsp"});
    tick();
    chk({tag, "_pready"}, 32'(pready), 32'h1);
    chk({tag, "_prdata"}, prdata, exp_rd);
    chk({tag, "_done_mready"}, 32'(mem_ready), 32'h0);
    tick();
    chk_idle_outputs({tag, "_idle"});
    chk({tag, "_idle_busy"}, 32'(busy), 32'h0);
  endtask

  // Both masters request reads together; both hold until their own ready.
  task automatic tie(input logic apb_first, input string tag);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 16'h0004;
    mem_valid = 1'b1; mem_addr = 32'h0000_0008; mem_wstrb = 4'h0;
    tick();
    chk({tag, "_first_addr"}, 32'(ram_addr), apb_first ? 32'd1 : 32'd2);
    tick();
    tick();
    chk({tag, "_first_pready"}, 32'(pready), apb_first ? 32'h1 : 32'h0);
    chk({tag, "_first_mready"}, 32'(mem_ready), apb_first ? 32'h0 : 32'h1);
    chk({tag, "_first_data"}, apb_first ? prdata : mem_rdata, apb_first ? 32'h0BAD_0001 : 32'h0BAD_0002);
    if (apb_first) begin psel = 1'b0; penable = 1'b0; end
    else mem_valid = 1'b0;
    tick();
    chk({tag, "_gap_busy"}, 32'(busy), 32'h0);
    tick();
    chk({tag, "_second_en"}, 32'(ram_en), 32'h1);
    chk({tag, "_second_addr"}, 32'(ram_addr), apb_first ? 32'd2 : 32'd1);
    psel = 1'b0; penable = 1'b0; mem_valid = 1'b0;
    tick();
    tick();
    chk({tag, "_second_pready"}, 32'(pready), apb_first ? 32'h0 : 32'h1);
    chk({tag, "_second_mready"}, 32'(mem_ready), apb_first ? 32'h1 : 32'h0);
    chk({tag, "_second_data"}, apb_first ? mem_rdata : prdata, apb_first ? 32'h0BAD_0002 : 32'h0BAD_0001);
    tick();
    chk_idle_outputs({tag, "_end"});
  endtask

  initial begin
    reset = 1'b1;
    paddr = 16'h0; pwrite = 1'b0; psel = 1'b0; penable = 1'b0; pwdata = 32'h0;
    mem_valid = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0;
    tick();
    tick();
    chk("rst_ram_en", 32'(ram_en), 32'h0);
    chk("rst_ram_we", 32'(ram_we), 32'h0);
    chk("rst_ram_addr", 32'(ram_addr), 32'h0);
    chk("rst_ram_wdata", ram_wdata, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk_idle_outputs("rst");
    reset = 1'b0;
    tick();

    core_xfer(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 32'd4, "core_wr");
    core_xfer(32'h0000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 32'd4, "core_rd");

    core_xfer(32'h0000_0000, 32'hFFFF_FFFF, 4'hF, 32'h0, 32'd0, "fill0");
    core_xfer(32'h0000_0000, 32'h1122_3344, 4'b0010, 32'h0, 32'd0, "strb_wr");
    apb_xfer(16'h0000, 1'b0, 32'h0, 32'hFFFF_33FF, 32'd0, "strb_rd");

    apb_xfer(16'h000C, 1'b1, 32'h1234_5678, 32'h0, 32'd3, "apb_wr");
    core_xfer(32'h0000_000C, 32'h0, 4'h0, 32'h1234_5678, 32'd3, "apb_wr_chk");

    core_xfer(32'h0000_0004, 32'h0BAD_0001, 4'hF, 32'h0, 32'd1, "pre1");
    core_xfer(32'h0000_0008, 32'h0BAD_0002, 4'hF, 32'h0, 32'd2, "pre2");

    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tie(1'b1, "tie_rst");
    apb_xfer(16'h0004, 1'b0, 32'h0, 32'h0BAD_0001, 32'd1, "apb_alone");
`ifdef SHARED_RAM_ARB_APB_PRIO_EN
    tie(1'b1, "tie_prio");
`else
    tie(1'b0, "tie_rr");
`endif

    core_xfer(32'h0001_0000, 32'hA5A5_A5A5, 4'hF, 32'h0, 32'd0, "wrap_wr");
    apb_xfer(16'h0000, 1'b0, 32'h0, 32'hA5A5_A5A5, 32'd0, "wrap_rd");

    // Reset while the core read is in RSP.
    mem_valid = 1'b1; mem_addr = 32'h0000_0008; mem_wstrb = 4'h0;
    tick();
    mem_valid = 1'b0;
    tick();
    chk("mid_in_rsp_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_addr", 32'(ram_addr), 32'h0);
    chk("mid_rst_en", 32'(ram_en), 32'h0);
    chk_idle_outputs("mid_rst");
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_no_ready", 32'(mem_ready), 32'h0);
    end
    core_xfer(32'h0000_0008, 32'h0, 4'h0, 32'h0BAD_0002, 32'd2, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
